// File: rtl/single_port_ram_core.sv
// single_port_ram_core: synchronous single-port RAM, one shared address for
// reads and writes, registered read-data output, asynchronous active-low reset
// that clears the whole array and the output register.
// Optional feature macro: SPRAM_WRITE_FIRST_EN
//   defined   -> write-first: a write cycle drives the new data onto wdata.
//   undefined -> read-first (default): a write cycle drives the old contents.
module single_port_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADD_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0] wdata
);

  localparam int DEPTH = 1 << ADD_WIDTH;

  // Storage is built from resettable flops so the whole array clears on reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Current contents at the addressed word, before any write at this edge.
  always_comb begin
    rd_word_s = mem_q[addr];
  end

  // Next array state: only the addressed word changes, and only on a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (addr == ADD_WIDTH'(i))) begin
        mem_d[i] = data;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Next output word: reads return old contents; writes depend on the mode.
  always_comb begin
    wdata_d = rd_word_s;
`ifdef SPRAM_WRITE_FIRST_EN
    if (we) begin
      wdata_d = data;
    end else begin
      wdata_d = rd_word_s;
    end
`else
    wdata_d = rd_word_s;
`endif
  end

  // Array registers: cleared asynchronously, updated every rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read-data register: cleared asynchronously, loaded on every access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      wdata_q <= wdata_d;
    end
  end

  assign wdata = wdata_q;

endmodule

// File: tb/tb_single_port_ram_core.sv
// Testbench for single_port_ram_core: directed scenarios plus random traffic,
// checked against an array-based reference model of the RAM.
// Honours SPRAM_WRITE_FIRST_EN the same way as the design.
module tb_single_port_ram_core;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef SPRAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          we;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q;
  int            checks;
  int            errors;

  single_port_ram_core #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .data  (data),
    .addr  (addr),
    .wdata (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    exp_q = 8'h00;
  endtask

  // One access: drive at the falling edge, model at the rising edge, check 1 later.
  task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input string tag);
    logic [DW-1:0] old;
    @(negedge clk);
    we = w; addr = a; data = d;
    @(posedge clk);
    old = ref_mem[a];
    if (w) ref_mem[a] = d;
    exp_q = (w && WF) ? d : old;
    #1 chk(tag, wdata, exp_q);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; we = 1'b0; data = 8'h00; addr = 4'h0;
    model_clear();
    #2 chk("reset_state", wdata, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // All words read back as zero after reset.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, AW'(i), 8'h00, "post_reset_read");

    // Write / readback.
    cyc(1'b1, 4'd3, 8'hA5, "wr3");
    cyc(1'b1, 4'd15, 8'h5A, "wr15");
    cyc(1'b0, 4'd3, 8'h00, "rd3");
    chk("rd3_val", wdata, 8'hA5);
    cyc(1'b0, 4'd15, 8'h00, "rd15");
    chk("rd15_val", wdata, 8'h5A);

    // Read-during-write.
    cyc(1'b1, 4'd7, 8'h11, "wr7_first");
    cyc(1'b1, 4'd7, 8'h22, "wr7_rdw");
    chk("rdw_mode", wdata, WF ? 8'h22 : 8'h11);
    cyc(1'b0, 4'd7, 8'h00, "rd7_after");
    chk("rd7_val", wdata, 8'h22);

    // Back-to-back writes to one address.
    cyc(1'b1, 4'd0, 8'h01, "b2b_1");
    cyc(1'b1, 4'd0, 8'h02, "b2b_2");
    cyc(1'b1, 4'd0, 8'h03, "b2b_3");
    cyc(1'b0, 4'd0, 8'h00, "b2b_rd");
    chk("b2b_val", wdata, 8'h03);

    // Full sweep with addr^0xFF pattern.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, AW'(i), 8'(i) ^ 8'hFF, "sweep_wr");
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, AW'(i), 8'h00, "sweep_rd");
      chk("sweep_val", wdata, 8'(i) ^ 8'hFF);
    end

    // Reset mid-operation: half-cycle pulse between edges.
    cyc(1'b1, 4'd9, 8'hFF, "wr9");
    cyc(1'b0, 4'd9, 8'h00, "rd9_before");
    chk("rd9_before_val", wdata, 8'hFF);
    @(negedge clk);
    we = 1'b0; addr = 4'd9; data = 8'h00;
    #1 reset = 1'b0;
    #1 chk("rst_async", wdata, 8'h00);
    model_clear();
    #2 reset = 1'b1;
    @(posedge clk);
    #1 chk("rst_first_edge_rd9", wdata, 8'h00);

    // First edge after release performs a write normally.
    cyc(1'b1, 4'd2, 8'h3C, "wr_after_rst");
    chk("wr_after_rst_out", wdata, WF ? 8'h3C : 8'h00);
    cyc(1'b0, 4'd2, 8'h00, "rd2");
    chk("rd2_val", wdata, 8'h3C);

    // Reset held across a write edge: the write is lost.
    cyc(1'b1, 4'd5, 8'h77, "wr5");
    @(negedge clk);
    we = 1'b1; addr = 4'd9; data = 8'hFF;
    reset = 1'b0;
    @(posedge clk);
    #1 chk("rst_during_write", wdata, 8'h00);
    model_clear();
    @(negedge clk);
    reset = 1'b1; we = 1'b0; addr = 4'd9;
    @(posedge clk);
    #1 chk("rd9_after_lost_write", wdata, 8'h00);
    cyc(1'b0, 4'd5, 8'h00, "rd5_cleared");
    chk("rd5_cleared_val", wdata, 8'h00);

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
          DW'($urandom), "random");
    end

    // Final readback of the whole array.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, AW'(i), 8'h00, "final_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
